store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Store-side counterpart of the MEM-stage writeback read-select: performs the store direction into the data cache.
- Takes scalar and vector stores from the MEM stage (32-bit, 36-bit or 128-bit, addressed by line index plus sub-line select).
- Formats each store into a 128-bit line image with a bit-granular write mask, queues it in a small FIFO, and drains it to the data cache over a valid/ready handshake.
- Flags loads that hit a pending store so the pipeline can stall them.

Parameters:
- DEPTH, 4: number of buffered store entries; power of two, minimum 2.
- ADDR_W, 28: width of the cache-line address (byte address bits [31:4]).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- st_valid  input  1  store request valid.
- st_ready  output  1  buffer can accept a store.
- st_addr  input  ADDR_W  line address of the store.
- st_line  input  2  sub-line select; same encoding as the read path (line[1] selects the 64-bit half, line[0] selects the 32-bit word within it).
- st_type  input  2  00 none, 01 32-bit, 10 36-bit, 11 128-bit.
- st_data  input  128  store data, right-aligned for 32/36-bit stores.
- dc_valid  output  1  head entry valid toward the data cache.
- dc_ready  input  1  data cache accepts the head entry.
- dc_addr  output  ADDR_W  head line address.
- dc_data  output  128  head line image.
- dc_mask  output  128  per-bit write enable for the head entry.
- ld_addr  input  ADDR_W  line address of the load in MEM.
- ld_conflict  output  1  some valid entry matches ld_addr.
- count  output  $clog2(DEPTH)+1  occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Reset (rst low, async): head/tail pointers and count cleared; all entry valid bits cleared.
  - Output values during and after reset: count=0, empty=1, full=0, dc_valid=0, ld_conflict=0, st_ready=1.
  - Entry data/mask contents are don't-care, but dc_data and dc_mask drive 0 while empty.
- Formatting, with i = {st_line[1],st_line[0]} and h = st_line[1]:
  - type 01: data bits [32i+31:32i] = st_data[31:0]; mask ones in those 32 bits only.
  - type 10: data bits [64h+35:64h] = st_data[35:0]; mask ones in those 36 bits; st_line[0] ignored.
  - type 11: data = st_data; mask all ones; st_line ignored.
  - Every bit outside the mask is 0.
  - type 00 with st_valid=1: handshake completes, nothing enqueued, no state change.
- Enqueue:
  - Occurs on st_valid & st_ready & st_type!=00.
  - st_ready = !full. There is no same-cycle pass-through, so a full buffer blocks stores even while dc_ready=1.
- Dequeue:
  - dc_valid = !empty; dc_addr/dc_data/dc_mask come combinationally from the head entry.
  - The head pops on dc_valid & dc_ready.
- Latency: a store accepted in cycle N into an empty buffer shows dc_valid=1 in cycle N+1.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Ordering: strict FIFO. Entries reach the cache in acceptance order.
- Pointer wrap: pointers are modulo DEPTH; full and empty are derived from count.
- ld_conflict:
  - Combinational OR over valid entries of (entry_addr == ld_addr).
  - A store being accepted in the same cycle is not included.
  - An entry popping in the same cycle is still included.
- dc_valid/dc_* hold stable while dc_valid & !dc_ready.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined:
  - An accepted store merges into the tail entry when all of these hold: !empty, tail addr == st_addr, and the tail is not popping this cycle (not (count==1 & dc_ready)).
  - Merge rule: data = (old & ~new_mask) | new_data; mask = old_mask | new_mask.
  - count is unchanged by a merge.
  - st_ready remains !full (no merge into a full buffer).
- Undefined: every accepted non-00 store takes a new entry.

Test Plan:
- Reset then 32-bit store: addr 0x0000010, line 2'b10, data 0xDEADBEEF -> next cycle dc_valid=1, dc_data[95:64]=0xDEADBEEF, dc_mask=0x0000_0000_FFFF_FFFF_0000_0000_0000_0000, all other data bits 0.
- 36-bit store: line 2'b11, data 36'h9_12345678 -> dc_data[99:64]=36'h912345678, dc_mask bits [99:64] set, rest clear.
- Fill to DEPTH=4 with dc_ready=0:
  - count=4, full=1, st_ready=0; a 5th store is held.
  - Then dc_ready=1 -> entries drain in acceptance order; count decrements by 1 per cycle.
- With count=2, issue a store and raise dc_ready in the same cycle -> count stays 2; dc_addr advances to the second entry.
- Entry at addr 0x0ABC pending; ld_addr=0x0ABC -> ld_conflict=1. Entry popped -> ld_conflict=0 the cycle after the pop.
- STORE_COALESCE_EN, dc_ready=0:
  - Two 32-bit stores to addr 0x40, line 00 (0x11111111) then line 01 (0x22222222) -> count=1, dc_data[63:0]=0x22222222_11111111, mask[63:0] all ones.
  - Without the macro: count=2.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: formats 32/36/128-bit MEM-stage stores into 128-bit line
// images with a bit-granular write mask, queues them in a DEPTH-entry FIFO
// and drains them to the data cache over a valid/ready handshake. Loads in
// MEM that hit a pending entry are flagged through ld_conflict.
//
// Optional build macro: STORE_COALESCE_EN
//   defined   - a store to the same line as the (non-popping) tail entry is
//               merged into that entry instead of taking a new one.
//   undefined - every accepted store takes its own entry.

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [1:0]               st_line,
  input  logic [1:0]               st_type,
  input  logic [127:0]             st_data,
  output logic                     dc_valid,
  input  logic                     dc_ready,
  output logic [ADDR_W-1:0]        dc_addr,
  output logic [127:0]             dc_data,
  output logic [127:0]             dc_mask,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_W32  = 2'b01,
    ST_W36  = 2'b10,
    ST_W128 = 2'b11
  } st_type_e;

  // Entry storage; contents are only meaningful where valid_q is set.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [127:0]      data_q [DEPTH];
  logic [127:0]      mask_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [127:0]      fmt_data;
  logic [127:0]      fmt_mask;
  logic              enq;
  logic              deq;
  logic              merge;
  logic              push;

  // Place the store payload into its 128-bit line slot and build the mask.
  always_comb begin
    fmt_data = '0;
    fmt_mask = '0;
    case (st_type_e'(st_type))
      ST_W32: begin
        fmt_data = {96'b0, st_data[31:0]} << {st_line, 5'b0};
        fmt_mask = {96'b0, {32{1'b1}}}    << {st_line, 5'b0};
      end
      ST_W36: begin
        // 36-bit stores occupy the low end of a 64-bit half; word select ignored.
        fmt_data = {92'b0, st_data[35:0]} << {st_line[1], 6'b0};
        fmt_mask = {92'b0, {36{1'b1}}}    << {st_line[1], 6'b0};
      end
      ST_W128: begin
        fmt_data = st_data;
        fmt_mask = '1;
      end
      default: begin
        fmt_data = '0;
        fmt_mask = '0;
      end
    endcase
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign st_ready = !full;
  assign dc_valid = !empty;

  assign enq = st_valid & st_ready & (st_type != ST_NONE);
  assign deq = dc_valid & dc_ready;

`ifdef STORE_COALESCE_EN
  logic [PTR_W-1:0] tail_last;
  assign tail_last = tail_q - 1'b1;
  // A single entry that is popping this cycle must not absorb new bytes,
  // otherwise the merged data would be lost with the pop.
  assign merge = enq & !empty & (addr_q[tail_last] == st_addr)
               & !((count_q == CNT_W'(1)) & dc_ready);
`else
  assign merge = 1'b0;
`endif

  assign push = enq & !merge;

  // Next-state for pointers, occupancy and entry valid bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (deq) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    case ({push, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload write: new entry at the tail, or merge into the last one.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= fmt_data;
      mask_q[tail_q] <= fmt_mask;
    end
`ifdef STORE_COALESCE_EN
    if (merge) begin
      data_q[tail_last] <= (data_q[tail_last] & ~fmt_mask) | fmt_data;
      mask_q[tail_last] <= mask_q[tail_last] | fmt_mask;
    end
`endif
  end

  // Head entry toward the cache; forced to zero while the buffer is empty.
  always_comb begin
    dc_addr = '0;
    dc_data = '0;
    dc_mask = '0;
    if (!empty) begin
      dc_addr = addr_q[head_q];
      dc_data = data_q[head_q];
      dc_mask = mask_q[head_q];
    end
  end

  // Load hazard: any valid entry on the same line, popping ones included.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr)) begin
        ld_conflict = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer with a queue-based reference model.
// Honours STORE_COALESCE_EN the same way the design does.

module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 28;

  logic              clk;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [1:0]        st_line;
  logic [1:0]        st_type;
  logic [127:0]      st_data;
  logic              dc_valid;
  logic              dc_ready;
  logic [ADDR_W-1:0] dc_addr;
  logic [127:0]      dc_data;
  logic [127:0]      dc_mask;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_conflict;
  logic [2:0]        count;
  logic              empty;
  logic              full;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_line(st_line), .st_type(st_type), .st_data(st_data),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr),
    .dc_data(dc_data), .dc_mask(dc_mask),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [127:0]      d;
    logic [127:0]      m;
  } ent_t;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference formatting: walk the bit slot the store type selects.
  function automatic ent_t fmt(input logic [ADDR_W-1:0] a, input logic [1:0] ln,
                               input logic [1:0] ty, input logic [127:0] d);
    ent_t e;
    int lo, w;
    e.a = a; e.d = '0; e.m = '0;
    lo = 0; w = 0;
    if (ty == 2'd1) begin lo = 32 * ln; w = 32; end
    else if (ty == 2'd2) begin lo = 64 * ln[1]; w = 36; end
    else if (ty == 2'd3) begin lo = 0; w = 128; end
    for (int b = 0; b < 128; b++) begin
      if (b >= lo && b < lo + w) begin
        e.m[b] = 1'b1;
        e.d[b] = d[b - lo];
      end
    end
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_dcv"}, dc_valid, 0);
    chk({tag, "_ldc"}, ld_conflict, 0);
    chk({tag, "_str"}, st_ready, 1);
    chk({tag, "_dcd"}, dc_data, 0);
    chk({tag, "_dcm"}, dc_mask, 0);
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance model.
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [1:0] ln,
                      input logic [1:0] ty, input logic [127:0] d, input logic rdy,
                      input logic [ADDR_W-1:0] la);
    int n;
    logic conf, accept, pop, mrg;
    ent_t e;
    @(negedge clk);
    st_valid = v; st_addr = a; st_line = ln; st_type = ty; st_data = d;
    dc_ready = rdy; ld_addr = la;
    #1;
    n = mq.size();
    conf = 1'b0;
    foreach (mq[k]) if (mq[k].a == la) conf = 1'b1;
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("st_ready", st_ready, n < DEPTH);
    chk("dc_valid", dc_valid, n > 0);
    chk("ld_conflict", ld_conflict, conf);
    if (n > 0) begin
      chk("dc_addr", dc_addr, mq[0].a);
      chk("dc_data", dc_data, mq[0].d);
      chk("dc_mask", dc_mask, mq[0].m);
    end else begin
      chk("dc_data_empty", dc_data, 0);
      chk("dc_mask_empty", dc_mask, 0);
    end
    accept = v && (n < DEPTH) && (ty != 2'b00);
    pop    = (n > 0) && rdy;
    mrg    = 1'b0;
    e      = fmt(a, ln, ty, d);
`ifdef STORE_COALESCE_EN
    if (accept && n > 0 && mq[n-1].a == a && !(n == 1 && rdy)) begin
      mrg = 1'b1;
      mq[n-1].d = (mq[n-1].d & ~e.m) | e.d;
      mq[n-1].m = mq[n-1].m | e.m;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (accept && !mrg) mq.push_back(e);
  endtask

  task automatic idle(input logic rdy, input logic [ADDR_W-1:0] la);
    step(1'b0, '0, 2'b00, 2'b00, '0, rdy, la);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1, '0);
  endtask

  initial begin
    rst = 1'b0;
    st_valid = 0; st_addr = '0; st_line = '0; st_type = '0; st_data = '0;
    dc_ready = 0; ld_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // 32-bit store into word 2
    step(1, 28'h0000010, 2'b10, 2'b01, 128'hDEADBEEF, 0, '0);
    idle(0, '0);
    chk("p32_data", dc_data[95:64], 32'hDEADBEEF);
    chk("p32_mask", dc_mask, 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000);
    chk("p32_rest", dc_data & ~dc_mask, 0);
    drain();

    // 36-bit store into upper half
    step(1, 28'h0000020, 2'b11, 2'b10, 128'h9_12345678, 0, '0);
    idle(0, '0);
    chk("p36_data", dc_data[99:64], 36'h912345678);
    chk("p36_mask", dc_mask, {28'h0, {36{1'b1}}, 64'h0});
    drain();

    // fill, blocked 5th store, ordered drain
    for (int i = 1; i <= DEPTH; i++)
      step(1, ADDR_W'(i), 2'b00, 2'b01, 128'(i), 0, '0);
    step(1, 28'h55, 2'b00, 2'b01, 128'h55, 0, '0);
    chk("fill_full", full, 1);
    chk("fill_ready", st_ready, 0);
    chk("fill_count", count, DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      idle(1, '0);
      chk("drain_addr", dc_addr, ADDR_W'(i));
    end
    drain();

    // simultaneous push and pop at count 2
    step(1, 28'hA1, 2'b00, 2'b11, 128'h1, 0, '0);
    step(1, 28'hA2, 2'b00, 2'b11, 128'h2, 0, '0);
    step(1, 28'hA3, 2'b00, 2'b11, 128'h3, 1, '0);
    idle(0, '0);
    chk("sim_count", count, 2);
    chk("sim_addr", dc_addr, 28'hA2);
    drain();

    // load conflict lifetime
    step(1, 28'h0ABC, 2'b01, 2'b01, 128'h7, 0, 28'h0ABC);
    idle(0, 28'h0ABC);
    chk("ldc_pending", ld_conflict, 1);
    idle(1, 28'h0ABC);
    chk("ldc_popping", ld_conflict, 1);
    idle(0, 28'h0ABC);
    chk("ldc_after", ld_conflict, 0);

    // same-line 32-bit stores
    step(1, 28'h40, 2'b00, 2'b01, 128'h11111111, 0, '0);
    step(1, 28'h40, 2'b01, 2'b01, 128'h22222222, 0, '0);
    idle(0, '0);
`ifdef STORE_COALESCE_EN
    chk("coal_count", count, 1);
    chk("coal_data", dc_data[63:0], 64'h22222222_11111111);
    chk("coal_mask", dc_mask[63:0], {64{1'b1}});
`else
    chk("nocoal_count", count, 2);
`endif
    drain();

    // randomized traffic over a small line set to provoke hits and merges
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0,
           ADDR_W'(28'h40 + $urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) == 0,
           ADDR_W'(28'h40 + $urandom_range(0, 3)));
      if (c == 1500) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
